// File: rtl/btn_debounce_en_pkg.sv
// btn_debounce_en_pkg: shared state encodings and default debounce sizing
package btn_debounce_en_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_e;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int CNT_W_DEF = 20;
endpackage

// File: rtl/btn_debounce_en_if.sv
// btn_debounce_en_if: button/clear inputs and run-enable outputs of the debouncer
interface btn_debounce_en_if;
  logic btn;
  logic clr;
  logic en;
  logic press_pulse;
  logic btn_level;
  modport master(output btn, clr, input en, press_pulse, btn_level);
  modport slave(input btn, clr, output en, press_pulse, btn_level);
endinterface

// File: rtl/btn_debounce_en_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous board inputs
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  // shift the raw level through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/btn_debounce_en.sv
// btn_debounce_en: debounced push-button that toggles a run/stop enable per accepted press
module btn_debounce_en
  import btn_debounce_en_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  btn_debounce_en_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic en_q, en_d, pulse_q, pulse_d, level_q, level_d;
  logic s2, accept;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(bus.btn), .q(s2));
  // qualify presses and releases by counting consecutive stable synchronized samples
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    accept = 1'b0;
    cnt_inc = cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (s2) begin
        state_d = PRESS_CHK;
        cnt_d = '0;
      end
      PRESS_CHK: if (!s2) state_d = IDLE;
        else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          accept = 1'b1;
        end else cnt_d = cnt_inc;
      HELD: if (!s2) begin
        state_d = REL_CHK;
        cnt_d = '0;
      end
      REL_CHK: if (s2) state_d = HELD;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
        else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
    en_d = bus.clr ? 1'b0 : en_q ^ accept;
    pulse_d = accept;
    level_d = state_d == HELD || state_d == REL_CHK;
  end
  // register state, counter and all outputs so nothing reaches a port combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      en_q <= 1'b0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end
  assign bus.en = en_q;
  assign bus.press_pulse = pulse_q;
  assign bus.btn_level = level_q;
endmodule

// File: tb/tb_btn_debounce_en.sv
// tb_btn_debounce_en: cycle-by-cycle vector table plus a long-hold sequence
module tb_btn_debounce_en;
  typedef struct {
    logic rst;
    logic btn;
    logic clr;
    logic [2:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t vecs[$];
  btn_debounce_en_if bus();
  always #5 clk = ~clk;
  btn_debounce_en #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic add(input int n, input logic r, b, c, e, p, l);
    for (int i = 0; i < n; i++) vecs.push_back('{r, b, c, {e, p, l}});
  endtask
  task automatic step(input logic r, b, c);
    @(negedge clk);
    rst = r;
    bus.btn = b;
    bus.clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    int pulses;
    int first;
    bus.btn = 1'b0;
    bus.clr = 1'b0;
    // reset with button held, then re-qualification after release
    add(3, 1, 1, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1);
    add(4, 0, 1, 0, 1, 0, 1);
    add(6, 0, 0, 0, 1, 0, 1);
    add(2, 0, 0, 0, 1, 0, 0);
    // clr while idle with en=1
    add(1, 0, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0, 0);
    // press bounce: high 3, low 1, high 10
    add(3, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1);
    add(3, 0, 1, 0, 1, 0, 1);
    // release bounce: low 2, high 1, then low
    add(2, 0, 0, 0, 1, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1);
    add(6, 0, 0, 0, 1, 0, 1);
    add(2, 0, 0, 0, 1, 0, 0);
    // second clean press held 20 cycles: en back to 0
    add(6, 0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 1, 1);
    add(13, 0, 1, 0, 0, 0, 1);
    add(6, 0, 0, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0, 0);
    // press, then clr while held
    add(6, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1);
    add(2, 0, 1, 0, 1, 0, 1);
    add(1, 0, 1, 1, 0, 0, 1);
    add(2, 0, 1, 0, 0, 0, 1);
    add(6, 0, 0, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0, 0);
    // clr coincident with acceptance: pulse fires, en stays 0
    add(6, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 1);
    add(2, 0, 1, 0, 0, 0, 1);
    add(6, 0, 0, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0, 0);
    // reset mid-qualification (cnt=2) with button held
    add(5, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1);
    add(2, 0, 1, 0, 1, 0, 1);
    // reset while held with en=1 and clr asserted
    add(1, 1, 1, 1, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1);
    add(1, 0, 1, 0, 1, 0, 1);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn, vecs[i].clr);
      check($sformatf("vec%0d {en,pulse,level}", i),
            int'({bus.en, bus.press_pulse, bus.btn_level}), int'(vecs[i].exp));
    end
    // long hold: exactly one pulse, six edges after the first high sample
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    check("released level", int'(bus.btn_level), 0);
    pulses = 0;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0);
      if (bus.press_pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("hold pulse count", pulses, 1);
    check("hold pulse edge", first, 6);
    check("hold en", int'(bus.en), 0);
    check("hold level", int'(bus.btn_level), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btn_debounce_en.md
BTN_DEBOUNCE_EN -- requirements
Module: btn_debounce_en

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz): number of consecutive stable synchronized samples required to accept an edge; legal range 2 .. 2^20.
REQ-002 Parameter CNT_W, default 20: debounce counter width; SHALL satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock, all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-006 clr  input  1  synchronous request to force en low.
REQ-007 en  output  1  registered run/stop level, toggles on each accepted press; drives the downstream counter enable.
REQ-008 press_pulse  output  1  registered single-cycle strobe per accepted press.
REQ-009 btn_level  output  1  registered debounced button level.

Function
REQ-010 btn SHALL pass through a two-flop synchronizer; the FSM SHALL observe only the second-stage output (s2).
REQ-011 FSM states SHALL be: IDLE (stable released), PRESS_CHK (qualifying press), HELD (stable pressed), REL_CHK (qualifying release).
REQ-012 IDLE: s2=1 -> PRESS_CHK with cnt cleared to 0; otherwise stay.
REQ-013 PRESS_CHK: s2=0 -> IDLE (bounce rejected, no output change); s2=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD; otherwise cnt increments.
REQ-014 HELD: s2=0 -> REL_CHK with cnt cleared to 0; otherwise stay.
REQ-015 REL_CHK: s2=1 -> HELD (bounce rejected); s2=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt increments.
REQ-016 On the PRESS_CHK->HELD transition, press_pulse SHALL be 1 for exactly one cycle and en SHALL invert, both taking effect on the same edge.
REQ-017 Latency: with E0 the first edge sampling btn=1 and btn held high, press_pulse and the new en value SHALL appear after edge E0+DEBOUNCE_CYCLES+2.
REQ-018 btn_level SHALL be 1 in HELD and REL_CHK and 0 in IDLE and PRESS_CHK, registered.
REQ-019 Release acceptance SHALL NOT pulse or toggle anything; only btn_level changes.
REQ-020 The counter SHALL saturate at DEBOUNCE_CYCLES-1 and never wrap.
REQ-021 clr=1 SHALL force en to 0 on the next edge, regardless of state.
REQ-022 clr=1 coinciding with an accepted press: clr wins, en=0; press_pulse still asserts.
REQ-023 A held button SHALL produce exactly one press_pulse regardless of hold duration.

Reset
REQ-024 rst=1 at a rising edge SHALL set the state to IDLE, cnt=0, both synchronizer flops=0, en=0, press_pulse=0, btn_level=0.
REQ-025 Reset asserted mid-qualification or while HELD SHALL discard progress; a button still held after reset release SHALL be re-qualified from IDLE and produce a pulse.
REQ-026 rst SHALL take priority over clr and all FSM transitions.

Structure
REQ-027 State encodings (2-bit localparams) and the default DEBOUNCE_CYCLES SHALL live in a shared include file used by the block and its bench.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q), reusable for the other board inputs.
REQ-029 All outputs SHALL be flop outputs; there SHALL be no combinational path from btn or clr to any output.

Verification (benches override DEBOUNCE_CYCLES=4)
REQ-030 Reset: hold rst 3 cycles with btn=1 -> en=0, press_pulse=0, btn_level=0 throughout; after release, press_pulse at E0+6 with E0 the first post-reset edge.
REQ-031 Clean press: btn 0->1 at E0, held 20 cycles -> press_pulse high only in the cycle after E6, en 0->1 at E6, btn_level=1 from E6.
REQ-032 Bounce: btn high 3 cycles, low 1, high 10 -> single press_pulse, en toggles once, 6 cycles after the final rising sample.
REQ-033 Two presses separated by an 8-cycle release -> two pulses, en returns 0->1->0; release bounce of 2 cycles produces no pulse.
REQ-034 clr: en=1, assert clr 1 cycle -> en=0 next edge; clr coincident with press acceptance -> pulse=1, en=0.
REQ-035 Reset mid-PRESS_CHK (cnt=2) with btn held -> no pulse before reset; pulse 6 edges after reset release.
